// File: rtl/lc3_fetch_pkg.sv
// Shared LC-3 definitions for the fetch slice.
// Holds the 4-bit opcode constants found in ir[15:12] and the fetch FSM state encoding.
package lc3_fetch_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StReq    = 2'b01,
    StHold   = 2'b10,
    StHalted = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/lc3_fetch_decode.sv
// Register-file control decode for the instruction held in IR.
// Ports:
//   opcode     in  4  ir[15:12]
//   sr1_mux    out 1  0 selects ir[11:9] as SR1 (ST, STI), 1 otherwise
//   dr_mux     out 1  1 selects R7 as destination (JSR/JSRR, TRAP)
//   writes_reg out 1  opcode writes a general-purpose register
module lc3_fetch_decode
  import lc3_fetch_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       sr1_mux,
  output logic       dr_mux,
  output logic       writes_reg
);

  always_comb begin
    sr1_mux    = 1'b1;
    dr_mux     = 1'b0;
    writes_reg = 1'b0;
    case (opcode)
      OP_BR:   ;
      OP_ADD:  writes_reg = 1'b1;
      OP_LD:   writes_reg = 1'b1;
      OP_ST:   sr1_mux    = 1'b0;
      OP_JSR: begin
        dr_mux     = 1'b1;
        writes_reg = 1'b1;
      end
      OP_AND:  writes_reg = 1'b1;
      OP_LDR:  writes_reg = 1'b1;
      OP_STR:  ;
      OP_RTI:  ;
      OP_NOT:  writes_reg = 1'b1;
      OP_LDI:  writes_reg = 1'b1;
      OP_STI:  sr1_mux    = 1'b0;
      OP_JMP:  ;
      OP_RES:  ;
      OP_LEA:  writes_reg = 1'b1;
      OP_TRAP: begin
        dr_mux     = 1'b1;
        writes_reg = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_fetch.sv
// LC-3 instruction-fetch stage: owns PC and IR, reads instruction memory over a req/ack
// handshake and holds each instruction until execute reports completion.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   mem_req/mem_addr             read request and address (address is the PC)
//   mem_ack/mem_rdata            read completion and instruction word
//   exec_done/pc_load/pc_in/halt execute-stage completion, redirect and stop controls
//   pc, ir, ir_valid             fetch state visible to downstream stages
//   ir_slice/sr1_mux/dr_mux/writes_reg  register-file controls decoded from IR
module lc3_fetch
  import lc3_fetch_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = 16'h3000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              exec_done,
  input  logic              pc_load,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              halt,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [11:0]       ir_slice,
  output logic              sr1_mux,
  output logic              dr_mux,
  output logic              writes_reg
);

  localparam logic [DATA_W-1:0] PcOne = {{(DATA_W-1){1'b0}}, 1'b1};

  fetch_state_e      state_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic              mem_req_q;
  logic              ir_valid_q;

  // Outputs are registered alongside the state so they change only on the edge that
  // changes the state; reset clears them asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      mem_req_q  <= 1'b0;
      ir_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q   <= StReq;
          mem_req_q <= 1'b1;
        end
        StReq: begin
          if (mem_ack) begin
            ir_q       <= mem_rdata;
            pc_q       <= pc_q + PcOne;  // wraps modulo 2^DATA_W
            state_q    <= StHold;
            mem_req_q  <= 1'b0;
            ir_valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (exec_done) begin
            ir_valid_q <= 1'b0;
            // halt wins over a simultaneous redirect
            if (halt) begin
              state_q <= StHalted;
            end else begin
              if (pc_load) pc_q <= pc_in;
              state_q   <= StReq;
              mem_req_q <= 1'b1;
            end
          end
        end
        StHalted: ;
        default: begin
          state_q    <= StIdle;
          mem_req_q  <= 1'b0;
          ir_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign ir_slice = ir_q[11:0];

  lc3_fetch_decode u_decode (
    .opcode     (ir_q[15:12]),
    .sr1_mux    (sr1_mux),
    .dr_mux     (dr_mux),
    .writes_reg (writes_reg)
  );

endmodule

// File: tb/tb_lc3_fetch.sv
// Directed self-checking bench for lc3_fetch.
module tb_lc3_fetch;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        exec_done;
  logic        pc_load;
  logic [15:0] pc_in;
  logic        halt;
  logic [15:0] pc;
  logic [15:0] ir;
  logic        ir_valid;
  logic [11:0] ir_slice;
  logic        sr1_mux;
  logic        dr_mux;
  logic        writes_reg;

  int errors = 0;
  int checks = 0;

  lc3_fetch #(
    .DATA_W   (16),
    .RESET_PC (16'h3000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .exec_done  (exec_done),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .halt       (halt),
    .pc         (pc),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ir_slice   (ir_slice),
    .sr1_mux    (sr1_mux),
    .dr_mux     (dr_mux),
    .writes_reg (writes_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000; exec_done = 1'b0;
    pc_load = 1'b0; pc_in = 16'h0000; halt = 1'b0;
    tick();
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid: got %b want 0", ir_valid); end
    checks++; if (pc !== 16'h3000) begin errors++; $display("FAIL reset_pc: got %h want 3000", pc); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h want 0000", ir); end
    checks++; if ({sr1_mux, dr_mux, writes_reg} !== 3'b100) begin
      errors++; $display("FAIL reset_decode: got %b%b%b want 100", sr1_mux, dr_mux, writes_reg);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    tick();  // IDLE -> REQ
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL zw_req: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 16'h3000) begin errors++; $display("FAIL zw_addr: got %h want 3000", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'h1261;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    checks++; if (ir !== 16'h1261) begin errors++; $display("FAIL zw_ir: got %h want 1261", ir); end
    checks++; if (pc !== 16'h3001) begin errors++; $display("FAIL zw_pc: got %h want 3001", pc); end
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL zw_ir_valid: got %b want 1", ir_valid); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL zw_req_drop: got %b want 0", mem_req); end
    checks++; if ({sr1_mux, dr_mux, writes_reg} !== 3'b101) begin
      errors++; $display("FAIL zw_decode: got %b%b%b want 101", sr1_mux, dr_mux, writes_reg);
    end
    checks++; if (ir_slice !== 12'h261) begin errors++; $display("FAIL zw_slice: got %h want 261", ir_slice); end
    // A stray ack while holding must not disturb IR.
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    checks++; if (ir !== 16'h1261 || ir_valid !== 1'b1) begin
      errors++; $display("FAIL hold_stray_ack: got ir=%h v=%b want ir=1261 v=1", ir, ir_valid);
    end
  endtask

  task automatic test_wait_states();
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h3001) begin
      errors++; $display("FAIL seq_req: got req=%b addr=%h want req=1 addr=3001", mem_req, mem_addr);
    end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL seq_ir_valid: got %b want 0", ir_valid); end
    mem_rdata = 16'h3E05;  // present early; must not load before ack
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h3001 || ir !== 16'h1261) begin
        errors++;
        $display("FAIL wait_%0d: got req=%b addr=%h ir=%h want req=1 addr=3001 ir=1261",
                 i, mem_req, mem_addr, ir);
      end
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++; if (ir !== 16'h3E05 || pc !== 16'h3002) begin
      errors++; $display("FAIL wait_load: got ir=%h pc=%h want ir=3e05 pc=3002", ir, pc);
    end
    checks++; if ({sr1_mux, dr_mux, writes_reg} !== 3'b000) begin
      errors++; $display("FAIL st_decode: got %b%b%b want 000", sr1_mux, dr_mux, writes_reg);
    end
  endtask

  task automatic test_redirect_trap();
    exec_done = 1'b1; pc_load = 1'b1; pc_in = 16'h4000;
    tick();
    exec_done = 1'b0; pc_load = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h4000) begin
      errors++; $display("FAIL redirect: got req=%b addr=%h want req=1 addr=4000", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 16'hF025;
    tick();
    mem_ack = 1'b0;
    checks++; if (ir !== 16'hF025 || pc !== 16'h4001) begin
      errors++; $display("FAIL trap_load: got ir=%h pc=%h want ir=f025 pc=4001", ir, pc);
    end
    checks++; if ({sr1_mux, dr_mux, writes_reg} !== 3'b111) begin
      errors++; $display("FAIL trap_decode: got %b%b%b want 111", sr1_mux, dr_mux, writes_reg);
    end
  endtask

  task automatic test_wrap_halt();
    exec_done = 1'b1; pc_load = 1'b1; pc_in = 16'hFFFF;
    tick();
    exec_done = 1'b0; pc_load = 1'b0;
    checks++; if (mem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr: got %h want ffff", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'h5020;
    tick();
    mem_ack = 1'b0;
    checks++; if (pc !== 16'h0000 || ir !== 16'h5020) begin
      errors++; $display("FAIL wrap_pc: got pc=%h ir=%h want pc=0000 ir=5020", pc, ir);
    end
    exec_done = 1'b1; halt = 1'b1; pc_load = 1'b1; pc_in = 16'h1234;
    tick();
    exec_done = 1'b0; halt = 1'b0; pc_load = 1'b0;
    checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b0 || pc !== 16'h0000) begin
      errors++; $display("FAIL halt: got v=%b req=%b pc=%h want v=0 req=0 pc=0000", ir_valid, mem_req, pc);
    end
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1; exec_done = 1'b1; mem_rdata = 16'h1111;
      tick();
      checks++; if (mem_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 16'h5020 || pc !== 16'h0000) begin
        errors++;
        $display("FAIL halted_%0d: got req=%b v=%b ir=%h pc=%h want req=0 v=0 ir=5020 pc=0000",
                 i, mem_req, ir_valid, ir, pc);
      end
    end
    mem_ack = 1'b0; exec_done = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();  // IDLE -> REQ
    mem_ack = 1'b1; mem_rdata = 16'h2A00;
    tick();
    mem_ack = 1'b0;
    checks++; if (ir !== 16'h2A00 || pc !== 16'h3001 || writes_reg !== 1'b1) begin
      errors++; $display("FAIL ld_load: got ir=%h pc=%h wr=%b want ir=2a00 pc=3001 wr=1", ir, pc, writes_reg);
    end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    tick();  // still waiting for ack
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h3001) begin
      errors++; $display("FAIL pre_rst_req: got req=%b addr=%h want req=1 addr=3001", mem_req, mem_addr);
    end
    rst_n = 1'b0;
    #1;  // no clock edge in between
    checks++; if (mem_req !== 1'b0 || pc !== 16'h3000 || ir !== 16'h0000 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: got req=%b pc=%h ir=%h v=%b want req=0 pc=3000 ir=0000 v=0",
               mem_req, pc, ir, ir_valid);
    end
    mem_ack = 1'b1; mem_rdata = 16'h1ABC;
    tick();
    rst_n = 1'b1;
    tick();  // IDLE edge with the late ack still high
    mem_ack = 1'b0;
    checks++; if (ir !== 16'h0000 || mem_req !== 1'b1 || pc !== 16'h3000) begin
      errors++; $display("FAIL late_ack: got ir=%h req=%b pc=%h want ir=0000 req=1 pc=3000", ir, mem_req, pc);
    end
    mem_ack = 1'b1; mem_rdata = 16'h1261;
    tick();
    mem_ack = 1'b0;
    checks++; if (ir !== 16'h1261 || pc !== 16'h3001 || ir_valid !== 1'b1) begin
      errors++; $display("FAIL refetch: got ir=%h pc=%h v=%b want ir=1261 pc=3001 v=1", ir, pc, ir_valid);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_redirect_trap();
    test_wrap_halt();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_fetch.md
Name: lc3_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the register file.
- Holds the PC and issues a req/ack read to instruction memory.
- Latches the returned word into IR and drives ir_slice, sr1_mux, dr_mux and a write-enable hint to the register file.
- Holds each instruction until execute signals completion, then fetches the next one, optionally from a redirected PC.

Parameters:
- RESET_PC, 16'h3000, PC value loaded on reset (LC-3 user program origin).
- DATA_W, 16, instruction/address width; fixed at 16 for LC-3, parameterised for bench reuse only.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- mem_req  out  1  instruction read request.
- mem_addr  out  DATA_W  read address; equals pc while mem_req=1.
- mem_ack  in  1  memory has valid data this cycle.
- mem_rdata  in  DATA_W  instruction word, valid when mem_ack=1.
- exec_done  in  1  execute stage has finished the current instruction.
- pc_load  in  1  redirect request (branch/JMP/JSR/TRAP), qualified by exec_done.
- pc_in  in  DATA_W  redirect target.
- halt  in  1  stop fetching after the current instruction, qualified by exec_done.
- pc  out  DATA_W  current PC (already incremented past the instruction in IR).
- ir  out  DATA_W  instruction register.
- ir_valid  out  1  ir holds an instruction awaiting execution.
- ir_slice  out  12  ir[11:0], to register file.
- sr1_mux  out  1  0 selects ir[11:9] as SR1 (ST, STI); 1 otherwise.
- dr_mux  out  1  1 selects R7 as destination (JSR/JSRR 4'b0100, TRAP 4'b1111).
- writes_reg  out  1  opcode writes a GPR (ADD, AND, NOT, LD, LDI, LDR, LEA, JSR, TRAP); meaningful only when ir_valid=1.

Behaviour:
- Reset (async assert, sync deassert on next clk): state=IDLE, pc=RESET_PC, ir=16'h0000, mem_req=0, ir_valid=0. Decode outputs follow ir=0 (BR opcode): sr1_mux=1, dr_mux=0, writes_reg=0.
- FSM states and transitions:
  - IDLE: one cycle after reset release, then REQ. Outputs idle.
  - REQ: mem_req=1, mem_addr=pc.
    - On a posedge with mem_ack=1: ir<=mem_rdata, pc<=pc+1 (mod 2^16, so 16'hFFFF wraps to 16'h0000), go to HOLD.
    - mem_ack=0: stay; mem_req and mem_addr stable.
    - Zero-wait memory is supported (ack in the first REQ cycle), giving fetch latency = 1 cycle from REQ entry to ir_valid.
  - HOLD: ir_valid=1, mem_req=0; ir and pc stable.
    - exec_done=1 and halt=1: go to HALTED; halt has priority over pc_load.
    - exec_done=1 and pc_load=1: pc<=pc_in, then REQ.
    - exec_done=1 alone: go to REQ with the incremented pc.
    - exec_done=0: stay.
  - HALTED: ir_valid=0, mem_req=0. Only reset exits.
- ir_valid deasserts in the cycle after exec_done is sampled.
- mem_ack outside REQ is ignored; mem_rdata is never sampled outside REQ.
- exec_done, pc_load and halt are ignored outside HOLD.
- Reset mid-fetch drops mem_req asynchronously. A late ack after reset release lands in IDLE and is ignored.
- Decode (sr1_mux, dr_mux, writes_reg) is combinational from ir[15:12] only; no added latency.

Decomposition:
- Shared header lc3_defs holds:
  - opcode constants: OP_BR, OP_ADD, OP_LD, OP_ST, OP_JSR, OP_AND, OP_LDR, OP_STR, OP_RTI, OP_NOT, OP_LDI, OP_STI, OP_JMP, OP_RES, OP_LEA, OP_TRAP;
  - fetch state encodings (IDLE, REQ, HOLD, HALTED, 2 bits).
- One combinational sub-module, lc3_fetch_decode: maps ir[15:12] to sr1_mux, dr_mux and writes_reg. The FSM, PC and IR stay in lc3_fetch.

Test Plan:
- Reset then zero-wait memory returning 16'h1261 (ADD R1,R1,#1) at 16'h3000:
  - mem_addr=16'h3000 with mem_req=1 on the 2nd cycle;
  - next cycle: ir=16'h1261, pc=16'h3001, ir_valid=1, writes_reg=1, sr1_mux=1, dr_mux=0.
- Memory acks after 3 wait cycles: mem_req and mem_addr held constant for all 4 REQ cycles; ir is loaded only on the ack edge.
- HOLD with exec_done=1, pc_load=1, pc_in=16'h4000: next REQ shows mem_addr=16'h4000. With pc_load=0 instead, mem_addr=16'h3001.
- Fetch of 16'hF025 (TRAP x25): dr_mux=1, writes_reg=1. Fetch of 16'h3E05 (ST R7): sr1_mux=0, writes_reg=0.
- pc=16'hFFFF, ack: pc becomes 16'h0000. Then exec_done=1 with halt=1 and pc_load=1 together: HALTED, mem_req stays 0 despite pulsed ack and exec_done.
- rst_n low while in REQ awaiting ack: mem_req=0 immediately with no clock edge, pc=16'h3000, ir=0. A stray ack in the IDLE cycle leaves ir=0.
